// File: rtl/mult_mem_pkg.sv
// mult_mem_pkg: shared FSM state encoding and multiplier latency helper for the product buffer.
package mult_mem_pkg;

   typedef enum logic [2:0] {IDLE, FILL, WAIT_FLUSH, FULL, DRAIN} state_t;

   function automatic int mult_lat(input int in_w, input int digit);
      return 3 + $clog2((in_w / digit) * (in_w / digit));
   endfunction

endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: fixed-latency digit-serial-free multiplier; input reg, partial products, adder tree, sign fix.
module mult_pipe
   import mult_mem_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int DIGIT    = 4,
   parameter int WIDTH    = 2 * IN_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic                signed_i,
   input  logic [IN_WIDTH-1:0] a_i,
   input  logic [IN_WIDTH-1:0] b_i,
   output logic                valid_o,
   output logic [WIDTH-1:0]    prod_o
);

   localparam int ND  = IN_WIDTH / DIGIT;
   localparam int L   = $clog2(ND * ND);
   localparam int LAT = mult_lat(IN_WIDTH, DIGIT);
   localparam int NL  = 2 ** L;
   localparam int NN  = 2 * NL - 1;

   logic [LAT-1:0]      v_q;
   logic [L+1:0]        neg_q;
   logic                s_q;
   logic [IN_WIDTH-1:0] a_q, b_q, ma, mb;
   logic [WIDTH-1:0]    node_q [NN];
   logic [WIDTH-1:0]    leaf_d [NL];
   logic [WIDTH-1:0]    p_q;

   // Magnitudes are taken in IN_WIDTH bits unsigned, so the most negative operand maps exactly.
   always_comb begin
      ma = (s_q && a_q[IN_WIDTH-1]) ? -a_q : a_q;
      mb = (s_q && b_q[IN_WIDTH-1]) ? -b_q : b_q;
      for (int k = 0; k < NL; k++) leaf_d[k] = '0;
      for (int i = 0; i < ND; i++)
         for (int j = 0; j < ND; j++)
            leaf_d[i*ND+j] = (WIDTH'(ma[i*DIGIT +: DIGIT]) * WIDTH'(mb[j*DIGIT +: DIGIT])) << (DIGIT * (i + j));
   end

   always_ff @(posedge clk) begin
      if (!rst) v_q <= '0;
      else v_q <= {v_q[LAT-2:0], valid_i};
   end

   // Heap-ordered tree: node k sums children 2k+1, 2k+2; leaves occupy the upper half.
   always_ff @(posedge clk) begin
      a_q   <= a_i;
      b_q   <= b_i;
      s_q   <= signed_i;
      neg_q <= {neg_q[L:0], signed_i & (a_i[IN_WIDTH-1] ^ b_i[IN_WIDTH-1])};
      for (int k = 0; k < NL - 1; k++) node_q[k] <= node_q[2*k+1] + node_q[2*k+2];
      for (int k = 0; k < NL; k++) node_q[NL-1+k] <= leaf_d[k];
      p_q   <= neg_q[L+1] ? -node_q[0] : node_q[0];
   end

   assign valid_o = v_q[LAT-1];
   assign prod_o  = p_q;

endmodule

// File: rtl/mult_block_buffer.sv
// mult_block_buffer: multiplies operand pairs into a block of product memory, then streams the block out.
module mult_block_buffer
   import mult_mem_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int DIGIT    = 4,
   parameter int LOGDEPTH = 6,
   parameter int WIDTH    = 2 * IN_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                EN_mult,
   input  logic                mult_signed,
   input  logic [IN_WIDTH-1:0] mult_input0,
   input  logic [IN_WIDTH-1:0] mult_input1,
   output logic                RDY_mult,
   input  logic                EN_flush,
   output logic                EN_writeMem,
   output logic [LOGDEPTH-1:0] writeMem_addr,
   output logic [WIDTH-1:0]    writeMem_val,
   input  logic                EN_blockRead,
   output logic                EN_readMem,
   output logic [LOGDEPTH-1:0] readMem_addr,
   input  logic [WIDTH-1:0]    readMem_val,
   output logic                VALID_memVal,
   input  logic                RDY_memVal,
   output logic [WIDTH-1:0]    memVal_data,
   output logic [LOGDEPTH:0]   block_len
);

   localparam int DEPTH = 2 ** LOGDEPTH;
   localparam int CW    = LOGDEPTH + 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    acc_q, acc_d, wr_q, wr_d, rd_q, rd_d, out_q, out_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] sk_q [2], sk_d [2];
   logic             pend_q, accept, pv, pop, room;
   logic [WIDTH-1:0] prod;

   mult_pipe #(.IN_WIDTH(IN_WIDTH), .DIGIT(DIGIT), .WIDTH(WIDTH)) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (accept),
      .signed_i (mult_signed),
      .a_i      (mult_input0),
      .b_i      (mult_input1),
      .valid_o  (pv),
      .prod_o   (prod)
   );

   assign RDY_mult      = rst && (state_q == IDLE || (state_q == FILL && acc_q < CW'(DEPTH)));
   assign accept        = EN_mult && RDY_mult && !(state_q == FILL && EN_flush);
   assign EN_writeMem   = pv;
   assign writeMem_addr = wr_q[LOGDEPTH-1:0];
   assign writeMem_val  = pv ? prod : '0;
   assign VALID_memVal  = cnt_q != 2'd0;
   assign memVal_data   = sk_q[0];
   assign pop           = VALID_memVal && RDY_memVal;
   // A read may issue only if its return word is guaranteed a skid slot even if nothing drains meanwhile.
   assign room          = ({1'b0, cnt_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop});
   assign EN_readMem    = state_q == DRAIN && rd_q < wr_q && room;
   assign readMem_addr  = rd_q[LOGDEPTH-1:0];
   assign block_len     = wr_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q + CW'(accept);
      wr_d    = wr_q + CW'(pv);
      rd_d    = rd_q + CW'(EN_readMem);
      out_d   = out_q + CW'(pop);
      cnt_d   = cnt_q + {1'b0, pend_q} - {1'b0, pop};
      sk_d    = sk_q;
      if (pop) sk_d[0] = sk_q[1];
      if (pend_q) sk_d[cnt_q[0] ^ pop] = readMem_val;
      case (state_q)
         IDLE:       if (accept) state_d = FILL;
         FILL:       if (EN_flush) state_d = WAIT_FLUSH;
                     else if (acc_q == CW'(DEPTH) && wr_d == acc_q) state_d = FULL;
         WAIT_FLUSH: if (wr_d == acc_q) state_d = FULL;
         FULL:       if (EN_blockRead) state_d = DRAIN;
         DRAIN:      if (pop && out_d == wr_q) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        wr_d    = '0;
                        rd_d    = '0;
                        out_d   = '0;
                     end
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         sk_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         pend_q  <= EN_readMem;
         sk_q    <= sk_d;
      end
   end

endmodule
